// File: rtl/multicycle_controller_if.sv
// ---------------------------------------------------------------------------
// multicycle_controller_if
//
// Purpose: groups the instruction-decode inputs and the datapath control
// outputs of the multicycle controller into one bundle.
//
// Signals (controller view, modport master):
//   inputs  : Op[5:0], Funct[5:0]  instruction register fields
//             Zero                 ALU zero flag of the current cycle
//             MemReady             unified memory access completes this cycle
//   outputs : IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
//             ALUSrcA, Branch, PCWrite   datapath enables and selects
//             ALUSrcB[1:0], PCSrc[1:0], ALUControl[2:0]
//             PCEn                 PC load enable
//             State[3:0]           current state, for debug
// The slave modport is the datapath side of the same bundle.
// ---------------------------------------------------------------------------
interface multicycle_controller_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;

  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       Branch;
  logic       PCWrite;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [2:0] ALUControl;
  logic       PCEn;
  logic [3:0] State;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, Branch, PCWrite, ALUSrcB, PCSrc, ALUControl, PCEn, State
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, Branch, PCWrite, ALUSrcB, PCSrc, ALUControl, PCEn, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose: control FSM of a multicycle MIPS-style processor with a unified
// memory that may stall (MemReady). Supports lw, sw, R-type (add/sub/slt/mul),
// beq, addi and j. Unknown opcodes are dropped after DECODE.
//
// Ports:
//   clk  single clock, state updates on the rising edge
//   rst  asynchronous active-high reset, forces State to FETCH at once
//   bus  multicycle_controller_if.master (opcode/funct/zero/memready in,
//        all datapath control signals and the debug State out)
//
// All outputs are a combinational decode of the current state, Op, Funct
// and MemReady; Zero only feeds PCEn.
// ---------------------------------------------------------------------------
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011100;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU operation for an R-type instruction; unknown functs fall back to add.
  function automatic logic [2:0] alu_decode(input logic [5:0] funct);
    logic [2:0] op_v;
    case (funct)
      FN_SUB:  op_v = ALU_SUB;
      FN_SLT:  op_v = ALU_SLT;
      FN_MUL:  op_v = ALU_MUL;
      default: op_v = ALU_ADD;
    endcase
    return op_v;
  endfunction

  // State that follows DECODE for a given opcode.
  function automatic state_t decode_next(input logic [5:0] op);
    state_t ns_v;
    case (op)
      OP_LW, OP_SW: ns_v = S_MEMADR;
      OP_RTYPE:     ns_v = S_EXEC;
      OP_BEQ:       ns_v = S_BEQ;
      OP_ADDI:      ns_v = S_ADDIEX;
      OP_J:         ns_v = S_JUMP;
      default:      ns_v = S_FETCH;
    endcase
    return ns_v;
  endfunction

  state_t     state_r;
  state_t     next_state_s;

  logic       iord_s;
  logic       irwrite_s;
  logic       memwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic       branch_s;
  logic       pcwrite_s;
  logic [1:0] alusrcb_s;
  logic [1:0] pcsrc_s;
  logic [2:0] alucontrol_s;
  logic       fetch_done_s;

  // The instruction fetch completes only when memory answers and the
  // controller is not being held in reset; reset must never let the IR or PC
  // load.
  assign fetch_done_s = bus.MemReady & ~rst;

  // State register with asynchronous reset to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and output decode; every output starts at its idle value.
  always_comb begin
    next_state_s = S_FETCH;
    iord_s       = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regdst_s     = 1'b0;
    memtoreg_s   = 1'b0;
    regwrite_s   = 1'b0;
    alusrca_s    = 1'b0;
    branch_s     = 1'b0;
    pcwrite_s    = 1'b0;
    alusrcb_s    = SRCB_REG;
    pcsrc_s      = PC_ALU;
    alucontrol_s = ALU_ADD;

    case (state_r)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle but only written back when
        // the memory read of the instruction completes.
        alusrcb_s    = SRCB_FOUR;
        irwrite_s    = fetch_done_s;
        pcwrite_s    = fetch_done_s;
        next_state_s = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is precomputed here into ALUOut.
        alusrcb_s    = SRCB_IMMSH;
        next_state_s = decode_next(bus.Op);
      end
      S_MEMADR: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        next_state_s = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_s       = 1'b1;
        next_state_s = bus.MemReady ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg_s   = 1'b1;
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWR: begin
        // The write request is held until memory accepts it.
        iord_s       = 1'b1;
        memwrite_s   = 1'b1;
        next_state_s = bus.MemReady ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_REG;
        alucontrol_s = alu_decode(bus.Funct);
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_s     = 1'b1;
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_REG;
        alucontrol_s = ALU_SUB;
        pcsrc_s      = PC_ALUOUT;
        branch_s     = 1'b1;
        next_state_s = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_s    = 1'b1;
        alusrcb_s    = SRCB_IMM;
        next_state_s = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s   = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_s      = PC_JUMP;
        pcwrite_s    = 1'b1;
        next_state_s = S_FETCH;
      end
      default: begin
        // Unused encodings recover to FETCH with idle outputs.
        next_state_s = S_FETCH;
      end
    endcase
  end

  assign bus.IorD       = iord_s;
  assign bus.IRWrite    = irwrite_s;
  assign bus.MemWrite   = memwrite_s;
  assign bus.RegDst     = regdst_s;
  assign bus.MemtoReg   = memtoreg_s;
  assign bus.RegWrite   = regwrite_s;
  assign bus.ALUSrcA    = alusrca_s;
  assign bus.Branch     = branch_s;
  assign bus.PCWrite    = pcwrite_s;
  assign bus.ALUSrcB    = alusrcb_s;
  assign bus.PCSrc      = pcsrc_s;
  assign bus.ALUControl = alucontrol_s;
  // Zero only matters through the branch term; reset blocks any PC load.
  assign bus.PCEn       = ~rst & (pcwrite_s | (branch_s & bus.Zero));
  assign bus.State      = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench. Each instruction is expanded from its class (lw, sw,
// R-type, beq, addi, j, illegal) and its memory wait counts into a list of
// expected cycles (state, inputs to drive, expected controls); the list is
// then played against the DUT one cycle at a time. Directed instructions come
// first, then random ones, then an asynchronous reset in the middle of a load.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multicycle_controller;

  logic clk;
  logic rst;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: state, inputs driven, expected control vector.
  typedef struct packed {
    logic [3:0]  st;
    logic        mr;
    logic        z;
    logic [16:0] ctl;
  } cyc_t;

  cyc_t plan[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Control vector order: IorD IRWrite MemWrite RegDst MemtoReg RegWrite
  // ALUSrcA Branch PCWrite ALUSrcB PCSrc ALUControl PCEn
  function automatic logic [16:0] ctl(input logic iord, input logic irw, input logic mw,
                                      input logic rd, input logic m2r, input logic rw,
                                      input logic asa, input logic br, input logic pcw,
                                      input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic [2:0] alu, input logic z);
    return {iord, irw, mw, rd, m2r, rw, asa, br, pcw, asb, pcs, alu, pcw | (br & z)};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
            bus.ALUSrcA, bus.Branch, bus.PCWrite, bus.ALUSrcB, bus.PCSrc, bus.ALUControl,
            bus.PCEn};
  endfunction

  function automatic logic [2:0] ref_alu(input logic [5:0] f);
    if (f == 6'b100010) return 3'b100;
    else if (f == 6'b101010) return 3'b110;
    else if (f == 6'b011100) return 3'b101;
    else return 3'b010;
  endfunction

  // zsel: 0 drives Zero=0, 1 drives Zero=1, anything else random.
  function automatic logic pick_z(input int zsel);
    if (zsel == 0) return 1'b0;
    else if (zsel == 1) return 1'b1;
    else return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic z, input logic [16:0] c);
    cyc_t e;
    e.st = st; e.mr = mr; e.z = z; e.ctl = c;
    plan.push_back(e);
  endtask

  // Expand one instruction into its expected cycle sequence.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw_cnt, input int zsel);
    logic z;
    for (int i = 0; i < fw; i++) begin
      z = pick_z(zsel);
      push(4'd0, 1'b0, z, ctl(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, z));
    end
    z = pick_z(zsel);
    push(4'd0, 1'b1, z, ctl(0,1,0,0,0,0,0,0,1, 2'b01, 2'b00, 3'b010, z));
    z = pick_z(zsel);
    push(4'd1, rnd_bit(), z, ctl(0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010, z));
    if (op == 6'b100011 || op == 6'b101011) begin
      z = pick_z(zsel);
      push(4'd2, rnd_bit(), z, ctl(0,0,0,0,0,0,1,0,0, 2'b10, 2'b00, 3'b010, z));
      for (int i = 0; i <= mw_cnt; i++) begin
        z = pick_z(zsel);
        if (op == 6'b100011)
          push(4'd3, (i == mw_cnt), z, ctl(1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, z));
        else
          push(4'd5, (i == mw_cnt), z, ctl(1,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 3'b010, z));
      end
      if (op == 6'b100011) begin
        z = pick_z(zsel);
        push(4'd4, rnd_bit(), z, ctl(0,0,0,0,1,1,0,0,0, 2'b00, 2'b00, 3'b010, z));
      end
    end else if (op == 6'b000000) begin
      z = pick_z(zsel);
      push(4'd6, rnd_bit(), z, ctl(0,0,0,0,0,0,1,0,0, 2'b00, 2'b00, ref_alu(fn), z));
      z = pick_z(zsel);
      push(4'd7, rnd_bit(), z, ctl(0,0,0,1,0,1,0,0,0, 2'b00, 2'b00, 3'b010, z));
    end else if (op == 6'b000100) begin
      z = pick_z(zsel);
      push(4'd8, rnd_bit(), z, ctl(0,0,0,0,0,0,1,1,0, 2'b00, 2'b01, 3'b100, z));
    end else if (op == 6'b001000) begin
      z = pick_z(zsel);
      push(4'd9, rnd_bit(), z, ctl(0,0,0,0,0,0,1,0,0, 2'b10, 2'b00, 3'b010, z));
      z = pick_z(zsel);
      push(4'd10, rnd_bit(), z, ctl(0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010, z));
    end else if (op == 6'b000010) begin
      z = pick_z(zsel);
      push(4'd11, rnd_bit(), z, ctl(0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 3'b010, z));
    end
    // any other opcode returns to FETCH straight after DECODE
  endtask

  // Play the expected cycles: drive on the falling edge, compare 1 ns later.
  task automatic run(input logic [5:0] op, input logic [5:0] fn);
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(negedge clk);
      bus.Op       = op;
      bus.Funct    = fn;
      bus.MemReady = e.mr;
      bus.Zero     = e.z;
      #1;
      check("state", 32'(bus.State), 32'(e.st));
      check("ctl", 32'(observed()), 32'(e.ctl));
    end
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                       input int mw_cnt, input int zsel);
    build(op, fn, fw, mw_cnt, zsel);
    run(op, fn);
  endtask

  function automatic logic [5:0] rand_op(input int k);
    logic [5:0] o;
    case (k)
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: o = 6'b000000;
      3: o = 6'b000100;
      4: o = 6'b001000;
      5: o = 6'b000010;
      default: begin
        o = 6'($urandom_range(0, 63));
        while (o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b000100 || o == 6'b001000 || o == 6'b000010)
          o = 6'($urandom_range(0, 63));
      end
    endcase
    return o;
  endfunction

  function automatic logic [5:0] rand_fn();
    logic [5:0] f;
    case ($urandom_range(0, 3))
      0: f = 6'b100010;
      1: f = 6'b101010;
      2: f = 6'b011100;
      default: f = 6'($urandom_range(0, 63));
    endcase
    return f;
  endfunction

  // Hard stop in case the run ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.Op       = 6'b000000;
    bus.Funct    = 6'b000000;
    bus.Zero     = 1'b1;
    bus.MemReady = 1'b1;
    repeat (2) @(posedge clk);

    // Held in reset with memory ready: FETCH values, no IR/PC load.
    @(negedge clk);
    #1;
    check("rst_state", 32'(bus.State), 32'd0);
    check("rst_ctl", 32'(observed()), 32'(ctl(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1'b1)));
    bus.MemReady = 1'b0;
    rst = 1'b0;

    // Directed instructions
    instr(6'b100011, 6'b000000, 0, 0, 2);   // lw, no waits: 0,1,2,3,4
    instr(6'b000100, 6'b000000, 0, 0, 1);   // beq taken
    instr(6'b000100, 6'b000000, 0, 0, 0);   // beq not taken
    instr(6'b000000, 6'b101010, 3, 0, 2);   // fetch stalls 3 cycles, slt
    instr(6'b101011, 6'b000000, 0, 2, 2);   // sw with 2 wait cycles
    instr(6'b000000, 6'b011100, 0, 0, 2);   // mul
    instr(6'b000000, 6'b100000, 0, 0, 2);   // add
    instr(6'b111111, 6'b000000, 0, 0, 2);   // illegal opcode
    instr(6'b001000, 6'b000000, 1, 0, 2);   // addi
    instr(6'b000010, 6'b000000, 0, 0, 2);   // j
    instr(6'b100011, 6'b000000, 2, 3, 2);   // lw with stalls

    // Random instruction stream
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = rand_op($urandom_range(0, 6));
      fn = rand_fn();
      instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2);
    end

    // Asynchronous reset while a load waits in MEMRD
    @(negedge clk);
    bus.Op = 6'b100011;
    bus.MemReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    bus.MemReady = 1'b0;
    #1;
    check("memrd_wait", 32'(bus.State), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", 32'(bus.State), 32'd0);
    @(negedge clk);
    bus.MemReady = 1'b1;
    bus.Zero = 1'b1;
    #1;
    check("rst_hold_state", 32'(bus.State), 32'd0);
    check("rst_hold_ctl", 32'(observed()), 32'(ctl(0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010, 1'b1)));
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst", 32'(bus.State), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all widths and encodings fixed by this document.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 Op  in  6  opcode of instruction register contents.
REQ-005 Funct  in  6  function field of instruction register contents.
REQ-006 Zero  in  1  ALU zero flag from current cycle.
REQ-007 MemReady  in  1  unified memory access completes this cycle.
REQ-008 IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite  out  1 each  datapath enables and selects.
REQ-009 ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
REQ-010 PCSrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
REQ-011 ALUControl  out  3  010 add, 100 sub, 110 slt, 101 mul.
REQ-012 PCEn  out  1  PC load enable.
REQ-013 State  out  4  current state encoding, for debug.

Function
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11; encodings 12-15 return to FETCH on the next edge.
REQ-015 FETCH outputs: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=PCWrite=MemReady. Advance to DECODE when MemReady=1, else hold.
REQ-016 DECODE outputs: ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by Op: 100011 or 101011 -> MEMADR, 000000 -> EXEC, 000100 -> BEQ, 001000 -> ADDIEX, 000010 -> JUMP, any other -> FETCH.
REQ-017 MEMADR outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state: MEMRD if Op=100011, else MEMWR.
REQ-018 MEMRD outputs: IorD=1. Advance to MEMWB when MemReady=1, else hold.
REQ-019 MEMWB outputs: RegDst=0, MemtoReg=1, RegWrite=1. Next state: FETCH.
REQ-020 MEMWR outputs: IorD=1, MemWrite=1. MemWrite stays asserted every cycle until MemReady=1, then FETCH.
REQ-021 EXEC outputs: ALUSrcA=1, ALUSrcB=00. ALUControl by Funct: 100010 -> 100, 101010 -> 110, 011100 -> 101, any other -> 010. Next state: ALUWB.
REQ-022 ALUWB outputs: RegDst=1, MemtoReg=0, RegWrite=1. Next state: FETCH.
REQ-023 BEQ outputs: ALUSrcA=1, ALUSrcB=00, ALUControl=100, PCSrc=01, Branch=1. Next state: FETCH.
REQ-024 ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next state: ADDIWB.
REQ-025 ADDIWB outputs: RegDst=0, MemtoReg=0, RegWrite=1. Next state: FETCH.
REQ-026 JUMP outputs: PCSrc=10, PCWrite=1. Next state: FETCH.
REQ-027 Any output not listed for a state is 0; ALUControl defaults to 010.
REQ-028 PCEn = PCWrite OR (Branch AND Zero), combinational.
REQ-029 Outputs decode combinationally from State, Op, Funct and MemReady only; no output depends on Zero except PCEn.
REQ-030 MemReady is ignored in every state except FETCH, MEMRD and MEMWR.

Reset
REQ-031 rst=1 forces State=FETCH immediately, independent of clk, including mid-instruction and mid-wait.
REQ-032 While rst=1, all outputs take FETCH values with MemReady gating; while rst=1, IRWrite, PCWrite and PCEn are forced to 0.
REQ-033 On the first rising edge after rst deasserts, the FETCH transition rule applies normally.

Verification
REQ-034 lw (Op=100011), MemReady=1 constant -> State sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-035 beq (Op=000100), Zero=1 in state 8 -> PCEn=1, PCSrc=01. Repeat with Zero=0 -> PCEn=0. Both return to 0.
REQ-036 MemReady=0 for 3 cycles in FETCH, then 1 -> State holds 0 for 4 cycles with IRWrite=PCWrite=0, then =1 in the 4th cycle, then State=1.
REQ-037 sw with MemReady low 2 cycles in MEMWR -> MemWrite=1 for 3 consecutive cycles, then State=0.
REQ-038 R-type with Funct=101010 -> ALUControl=110 in EXEC. Funct=011100 -> 101. Funct=100000 -> 010.
REQ-039 Op=111111 -> State goes 0,1,0 with RegWrite and MemWrite never asserted. rst pulsed asynchronously in MEMRD -> State=0 before the next edge.
